perf_counter_bank: RTL

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank_if.sv | 31 +++
 rtl/perf_counter_bank.sv | 106 ++++++++++
 2 files changed

// File: rtl/perf_counter_bank_if.sv
// Bus bundle for perf_counter_bank: count controls, snapshot handshake and readout stream.
// The slave modport is the counter bank; the master modport is whoever drives it.
interface perf_counter_bank_if #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned CNT_WIDTH = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 enable;
    logic [NUM_CH-1:0]    event_i;
    logic                 clear;
    logic                 snap_req;
    logic                 snap_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH_W-1:0]      out_ch;
    logic [CNT_WIDTH-1:0] out_data;
    logic                 out_ovf;
    logic                 out_last;
    logic [NUM_CH-1:0]    ovf;

    modport master (
        output enable, event_i, clear, snap_req, out_ready,
        input  snap_ready, out_valid, out_ch, out_data, out_ovf, out_last, ovf
    );

    modport slave (
        input  enable, event_i, clear, snap_req, out_ready,
        output snap_ready, out_valid, out_ch, out_data, out_ovf, out_last, ovf
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters with sticky overflow flags. A snapshot copies all
// counters into shadow registers, which are then streamed out one channel per handshake.
module perf_counter_bank #(
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter bit          SATURATE      = 1'b1,
    parameter bit          CLEAR_ON_SNAP = 1'b0
) (
    input logic                clk,
    input logic                rst,
    perf_counter_bank_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CNT_WIDTH-1:0] cnt_q    [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d    [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] sh_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]    sh_ovf_q;
    logic                 capture;
    logic                 last;

    assign capture = (state_q == StIdle) && bus.snap_req;
    assign last    = (state_q == StStream) && (ch_q == LAST_CH);

    // Live counter next state: optional snapshot clear, then the increment, then clear.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = (capture && CLEAR_ON_SNAP) ? '0 : cnt_q[k];
            ovf_d[k] = (capture && CLEAR_ON_SNAP) ? 1'b0 : ovf_q[k];
            if (bus.enable && bus.event_i[k]) begin
                if (&cnt_d[k]) begin
                    ovf_d[k] = 1'b1;
                    if (!SATURATE) begin
                        cnt_d[k] = '0;
                    end
                end else begin
                    cnt_d[k] = cnt_d[k] + CNT_WIDTH'(1);
                end
            end
            if (bus.clear) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            StIdle: begin
                if (bus.snap_req) begin
                    state_d = StStream;
                    ch_d    = '0;
                end
            end
            StStream: begin
                if (bus.out_ready) begin
                    if (last) begin
                        state_d = StIdle;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            cnt_q    <= '{default: '0};
            ovf_q    <= '0;
            sh_cnt_q <= '{default: '0};
            sh_ovf_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            // Shadows hold the pre-increment values seen in the capture cycle.
            if (capture) begin
                sh_cnt_q <= cnt_q;
                sh_ovf_q <= ovf_q;
            end
        end
    end

    always_comb begin
        bus.snap_ready = (state_q == StIdle);
        bus.out_valid  = (state_q == StStream);
        bus.out_last   = last;
        bus.out_ch     = ch_q;
        bus.out_data   = sh_cnt_q[ch_q];
        bus.out_ovf    = sh_ovf_q[ch_q];
        bus.ovf        = ovf_q;
    end
endmodule
